tetris_ctrl_conditioner: RTL and testbench
==========================================

TETRIS_CTRL_CONDITIONER -- requirements
Module: tetris_ctrl_conditioner

Interface
REQ-001 Parameters SHALL be: DEBOUNCE_CYCLES, default 4, consecutive stable samples needed to accept a level change (at least 1).
REQ-002 REPEAT_DELAY, default 10, hold cycles from the initial pulse to the first auto-repeat pulse (at least 1).
REQ-003 REPEAT_PERIOD, default 3, cycles between auto-repeat pulses (at least 1).
REQ-004 GRAVITY_PERIOD, default 8, cycles per gravity step (at least 2).
REQ-005 Port: clk  in  1  single clock; every register is on its rising edge.
REQ-006 Port: reset_n  in  1  asynchronous, active-low reset.
REQ-007 Port: btn_raw  in  6  asynchronous button levels, active-high; bit 5..0 = left, right, down, rot-left, rot-right, reset-game, matching the game g_ctrl ordering.
REQ-008 Port: ctrl_pulse  out  6  one-cycle command pulses, same bit order; feeds the game g_ctrl.
REQ-009 Port: btn_level  out  6  debounced button levels.
REQ-010 Port: step_tick  out  1  one-cycle gravity strobe.

Function
REQ-011 Each btn_raw bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-012 Each bit SHALL have a debounce counter, width clog2(DEBOUNCE_CYCLES+1):
- increments on each cycle where the synchronized value differs from btn_level;
- clears on any cycle where they match.
REQ-013 btn_level SHALL toggle on the edge where DEBOUNCE_CYCLES consecutive differing samples complete; the counter clears on that same edge.
REQ-014 A registered rising edge of btn_level SHALL produce exactly one ctrl_pulse cycle on the next edge. Total latency is DEBOUNCE_CYCLES+2 edges, with edge 0 being the first edge that samples the new raw value.
REQ-015 A falling edge of btn_level SHALL produce no pulse.
REQ-016 Auto-repeat applies to left, right and down only.
- While btn_level is high, a per-bit hold counter runs.
- First repeat pulse: REPEAT_DELAY cycles after the initial pulse.
- Later repeat pulses: every REPEAT_PERIOD cycles.
REQ-017 Rot-left, rot-right and reset-game SHALL pulse once per press and never repeat.
REQ-018 A falling btn_level SHALL clear that bit's hold counter on the same edge, and no further pulse SHALL be issued for that bit.
REQ-019 Hold counters SHALL saturate or wrap inside their repeat phase only; a long hold SHALL never stop the repeats and never emit a spurious extra pulse.
REQ-020 If left and right pulses fall in the same cycle, both SHALL be suppressed for that cycle. Their hold counters continue unaffected.
REQ-021 The gravity counter, width clog2(GRAVITY_PERIOD), SHALL count 0..GRAVITY_PERIOD-1 and wrap.
REQ-022 step_tick SHALL be high for exactly the one cycle in which the gravity counter equals GRAVITY_PERIOD-1.
REQ-023 In a cycle where ctrl_pulse[0] (reset-game) is high:
- the gravity counter SHALL load 0;
- step_tick SHALL be forced low, even if the count would have matched.
REQ-024 Simultaneous presses of different bits SHALL be processed independently, except for the left/right rule in REQ-020.
REQ-025 ctrl_pulse SHALL be glitch-free, driven directly from registers.

Reset
REQ-026 While reset_n is low, the following SHALL all be 0 asynchronously: synchronizers, debounce counters, btn_level, hold counters, the gravity counter, ctrl_pulse and step_tick.
REQ-027 Reset released mid-press: a button still held SHALL produce one fresh initial pulse DEBOUNCE_CYCLES+2 edges after release (btn_level restarts at 0). Repeat timing then restarts from that pulse.
REQ-028 Reset asserted mid-pulse or mid-repeat SHALL clear the outputs immediately, with no residual pulse after release.

Verification (defaults)
REQ-029 Scenario: rot-left raw held high for 20 cycles. Required: exactly one ctrl_pulse[2] at edge 6; btn_level[2] rises at edge 5.
REQ-030 Scenario: left raw toggles every 2 cycles for 12 cycles, then stays low. Required: btn_level[5] stays 0 and no pulse is issued.
REQ-031 Scenario: down held for 30 cycles. Required:
- pulses at edges 6, 16, 19, 22, 25, 28, 31, 34;
- the first pulse after release is none, with release debounced at 4 cycles.
REQ-032 Scenario: left and right rise on the same cycle and are held. Required: no pulse at edge 6, and none on repeat edges either, since they coincide.
REQ-033 Scenario: idle run from reset release. Required: step_tick at edges 7, 15, 23; a reset-game pulse landing at edge 15 suppresses that tick, and the next tick comes at edge 23.
REQ-034 Scenario: reset_n pulsed low at edge 18 of the REQ-031 run and released at edge 20. Required: outputs are 0 during reset, then a new initial pulse at edge 26 and a repeat at edge 36.

Source files
------------

// File: rtl/tetris_ctrl_conditioner.sv
// tetris_ctrl_conditioner: turns raw Tetris buttons into debounced, auto-repeating command pulses plus a gravity strobe
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   btn_raw    raw button levels {left, right, down, rot_left, rot_right, reset_game}
//   ctrl_pulse one-cycle command pulses, same bit order
//   btn_level  debounced button levels
//   step_tick  one-cycle gravity strobe
module tetris_ctrl_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 10,
    parameter int REPEAT_PERIOD   = 3,
    parameter int GRAVITY_PERIOD  = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] btn_raw,
    output logic [5:0] ctrl_pulse,
    output logic [5:0] btn_level,
    output logic       step_tick
);
    localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HMAX = REPEAT_DELAY > REPEAT_PERIOD ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int HW   = $clog2(HMAX + 1);
    localparam int GW   = $clog2(GRAVITY_PERIOD);
    localparam logic [DW-1:0] DB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] DELAY_V  = HW'(REPEAT_DELAY);
    localparam logic [HW-1:0] PERIOD_V = HW'(REPEAT_PERIOD);
    localparam logic [GW-1:0] G_LAST   = GW'(GRAVITY_PERIOD - 1);

    logic [5:0]    sync1, sync2, level_d, level_nxt, pulse_nxt;
    logic [DW-1:0] db_cnt [6];
    logic [DW-1:0] db_nxt [6];
    // hold counters exist only for the repeating buttons (bits 3..5), indexed j = bit-3
    logic [HW-1:0] hold_cnt [3];
    logic [HW-1:0] hold_nxt [3];
    logic [2:0]    in_rep, rep_nxt;
    logic [GW-1:0] grav;

    always_comb begin
        level_nxt = btn_level;
        pulse_nxt = btn_level & ~level_d;
        for (int i = 0; i < 6; i++) begin
            db_nxt[i] = '0;
            if (sync2[i] != btn_level[i]) begin
                if (db_cnt[i] == DB_LAST) level_nxt[i] = ~btn_level[i];
                else db_nxt[i] = db_cnt[i] + 1'b1;
            end
        end
        // the hold counter counts edges since the last pulse; it first waits the
        // repeat delay, then cycles through the repeat period, so it never overflows
        for (int j = 0; j < 3; j++) begin
            hold_nxt[j] = '0;
            rep_nxt[j]  = 1'b0;
            // looking at level_nxt kills a repeat on the very edge the level falls
            if (btn_level[j+3] && level_d[j+3] && level_nxt[j+3]) begin
                if (hold_cnt[j] + 1'b1 == (in_rep[j] ? PERIOD_V : DELAY_V)) begin
                    pulse_nxt[j+3] = 1'b1;
                    rep_nxt[j]     = 1'b1;
                end else begin
                    hold_nxt[j] = hold_cnt[j] + 1'b1;
                    rep_nxt[j]  = in_rep[j];
                end
            end
        end
        if (pulse_nxt[5] && pulse_nxt[4]) pulse_nxt[5:4] = 2'b00;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1      <= '0;
            sync2      <= '0;
            db_cnt     <= '{default: '0};
            btn_level  <= '0;
            level_d    <= '0;
            hold_cnt   <= '{default: '0};
            in_rep     <= '0;
            ctrl_pulse <= '0;
            grav       <= '0;
        end else begin
            sync1      <= btn_raw;
            sync2      <= sync1;
            db_cnt     <= db_nxt;
            btn_level  <= level_nxt;
            level_d    <= btn_level;
            hold_cnt   <= hold_nxt;
            in_rep     <= rep_nxt;
            ctrl_pulse <= pulse_nxt;
            grav       <= (ctrl_pulse[0] || grav == G_LAST) ? '0 : grav + 1'b1;
        end
    end

    // a reset-game pulse restarts gravity and swallows any tick in its cycle
    assign step_tick = (grav == G_LAST) && !ctrl_pulse[0];
endmodule

// File: tb/tb_tetris_ctrl_conditioner.sv
// tb_tetris_ctrl_conditioner: directed and random checks of the button conditioner against an edge-level model
module tb_tetris_ctrl_conditioner;
    localparam int DC = 4, RD = 10, RP = 3, GP = 8;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [5:0] btn_raw, ctrl_pulse, btn_level;
    logic       step_tick;

    tetris_ctrl_conditioner #(
        .DEBOUNCE_CYCLES(DC), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP), .GRAVITY_PERIOD(GP)
    ) dut (
        .clk(clk), .reset_n(reset_n), .btn_raw(btn_raw),
        .ctrl_pulse(ctrl_pulse), .btn_level(btn_level), .step_tick(step_tick)
    );

    always #5 clk = ~clk;

    int n_chk, n_fail;
    // reference model: synchronizer view, debounced level, edge of the initial
    // pulse per bit, and a gravity phase counted in edges
    logic [5:0] m_s1, m_s2, m_lvl, m_lvl_prev, m_pulse;
    logic       m_tick;
    int         m_streak [6];
    int         m_t0 [6];
    int         m_g, tabs;
    // scenario bookkeeping: edge number within scenario and observed events
    int         ed, rise_ed;
    logic [5:0] mon_mask;
    int         pq[$];
    int         tq[$];

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_lvl = '0; m_lvl_prev = '0; m_pulse = '0; m_tick = 1'b0; m_g = 0;
        for (int b = 0; b < 6; b++) begin
            m_streak[b] = 0;
            m_t0[b] = -1;
        end
    endtask

    task automatic model_edge();
        logic [5:0] nl, np, rise;
        int k;
        nl = m_lvl;
        for (int b = 0; b < 6; b++) begin
            if (m_s2[b] != m_lvl[b]) begin
                m_streak[b]++;
                if (m_streak[b] == DC) begin
                    nl[b] = ~m_lvl[b];
                    m_streak[b] = 0;
                end
            end else m_streak[b] = 0;
        end
        rise = m_lvl & ~m_lvl_prev;
        np = '0;
        for (int b = 0; b < 6; b++) begin
            if (rise[b]) begin
                np[b] = 1'b1;
                m_t0[b] = tabs;
            end else if (b >= 3 && m_lvl[b] && nl[b] && m_t0[b] >= 0) begin
                k = tabs - m_t0[b];
                if (k >= RD && (k - RD) % RP == 0) np[b] = 1'b1;
            end
            if (!nl[b]) m_t0[b] = -1;
        end
        if (np[5] && np[4]) np[5:4] = 2'b00;
        m_g = m_pulse[0] ? 0 : (m_g + 1) % GP;
        m_s2 = m_s1;
        m_s1 = btn_raw;
        m_lvl_prev = m_lvl;
        m_lvl = nl;
        m_pulse = np;
        m_tick = (m_g == GP - 1) && !np[0];
    endtask

    task automatic check();
        n_chk += 3;
        assert (ctrl_pulse === m_pulse) else begin
            n_fail++;
            $error("FAIL ctrl_pulse ed=%0d got=%b exp=%b", ed, ctrl_pulse, m_pulse);
        end
        assert (btn_level === m_lvl) else begin
            n_fail++;
            $error("FAIL btn_level ed=%0d got=%b exp=%b", ed, btn_level, m_lvl);
        end
        assert (step_tick === m_tick) else begin
            n_fail++;
            $error("FAIL step_tick ed=%0d got=%b exp=%b", ed, step_tick, m_tick);
        end
    endtask

    // one clock: drive at negedge, observe 1 time unit after the rising edge
    task automatic step(input logic [5:0] raw, input logic rn);
        @(negedge clk);
        btn_raw = raw;
        reset_n = rn;
        if (!rn) begin
            model_reset();
            #1 check();
        end
        @(posedge clk);
        if (rn) begin
            model_edge();
            tabs++;
        end
        #1 check();
        if ((ctrl_pulse & mon_mask) != 0) pq.push_back(ed);
        if ((btn_level & mon_mask) != 0 && rise_ed < 0) rise_ed = ed;
        if (step_tick) tq.push_back(ed);
        ed++;
    endtask

    task automatic run(input logic [5:0] raw, input int n);
        for (int i = 0; i < n; i++) step(raw, 1'b1);
    endtask

    task automatic start(input logic [5:0] mask);
        ed = 0; rise_ed = -1; mon_mask = mask;
        pq.delete();
        tq.delete();
    endtask

    task automatic chk_list(input string tag, input int got[$], input int exp[$]);
        n_chk++;
        assert (got.size() == exp.size()) else begin
            n_fail++;
            $error("FAIL %s count got=%0d exp=%0d", tag, got.size(), exp.size());
        end
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            n_chk++;
            assert (got[i] == exp[i]) else begin
                n_fail++;
                $error("FAIL %s[%0d] edge got=%0d exp=%0d", tag, i, got[i], exp[i]);
            end
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        n_chk++;
        assert (got == exp) else begin
            n_fail++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    initial begin
        logic [5:0] r;
        n_chk = 0; n_fail = 0; tabs = 0;
        btn_raw = '0; reset_n = 1'b0; mon_mask = '0; ed = 0; rise_ed = -1;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check();

        // rot-left held 20 cycles: level rises at edge 5, single pulse at edge 6
        start(6'b000100);
        run(6'b000100, 20);
        run(6'b000000, 12);
        chk_list("rotl_pulse", pq, '{6});
        chk_int("rotl_rise", rise_ed, 5);

        // left chattering every 2 cycles never settles
        start(6'b100000);
        for (int i = 0; i < 3; i++) begin
            run(6'b100000, 2);
            run(6'b000000, 2);
        end
        run(6'b000000, 10);
        chk_int("chatter_pulses", pq.size(), 0);
        chk_int("chatter_rise", rise_ed, -1);

        // down held 30 cycles: initial, delayed repeat, periodic repeats, nothing after release
        start(6'b001000);
        run(6'b001000, 30);
        run(6'b000000, 15);
        chk_list("down_pulse", pq, '{6, 16, 19, 22, 25, 28, 31, 34});

        // left+right together: every pulse coincides and is suppressed
        start(6'b110000);
        run(6'b110000, 40);
        run(6'b000000, 10);
        chk_int("lr_pulses", pq.size(), 0);
        chk_int("lr_rise", rise_ed, 5);

        // down held with reset at edges 18..19: fresh pulse at 26, repeat at 36
        // and 39; the repeat due at 42 collides with the release and is dropped
        start(6'b001000);
        run(6'b001000, 18);
        step(6'b001000, 1'b0);
        step(6'b001000, 1'b0);
        run(6'b001000, 17);
        run(6'b000000, 12);
        chk_list("rst_pulse", pq, '{6, 16, 26, 36, 39});

        // gravity from reset release; ticks are recorded at the edge before the
        // one that samples them, and a reset-game pulse on edge 14 swallows a tick
        step(6'b000000, 1'b0);
        step(6'b000000, 1'b0);
        start(6'b000001);
        run(6'b000000, 8);
        run(6'b000001, 4);
        run(6'b000000, 20);
        chk_list("grav_tick", tq, '{6, 22, 30});
        chk_list("game_pulse", pq, '{14});

        // random presses with long holds on repeating keys and occasional resets
        start(6'b000000);
        r = '0;
        for (int i = 0; i < 1500; i++) begin
            for (int b = 0; b < 6; b++)
                if ($urandom_range(b >= 3 ? 39 : 9) == 0) r[b] = ~r[b];
            if ($urandom_range(299) == 0) begin
                step(r, 1'b0);
                step(r, 1'b0);
            end else step(r, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
